// File: rtl/spi_cmd_serializer.sv
// spi_cmd_serializer
// Turns one register command (rw, address, up to MAX_BYTES payload bytes)
// into the byte stream consumed by spi_master_byte: instruction byte first,
// then payload bytes MSB first. Each command becomes its own SPI frame.
// Between commands have_data stays low until cs_n is released, followed by
// a guard gap.
//
// Optional build macro: SPI_SER_RD_CAPTURE_EN
//   When defined, read commands capture the bytes returned on miso_reg
//   (instruction slot discarded) into rd_data and pulse rd_valid at the end
//   of the frame. When undefined, rd_data and rd_valid are tied to zero.
//
// Handshakes:
//   cmd_valid/cmd_ready - a command transfers on a clk edge where both are 1.
//     cmd_ready depends only on state, never on cmd_valid. A command offered
//     while cmd_ready=0 is neither latched nor queued.
//   have_data/rdreq     - data_o is show-ahead and valid whenever have_data=1.
//     A byte is consumed on a clk edge where both are 1. rdreq while
//     have_data=0 is ignored.
module spi_cmd_serializer #(
    parameter int MAX_BYTES  = 8,
    parameter int GAP_CYCLES = 4,
    parameter int ADDR_W     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rw,
    input  logic [ADDR_W-1:0]      cmd_addr,
    input  logic [3:0]             cmd_len,
    input  logic [8*MAX_BYTES-1:0] cmd_data,
    output logic                   have_data,
    output logic [7:0]             data_o,
    input  logic                   rdreq,
    input  logic                   cs_n,
    output logic                   busy,
    output logic                   frame_done,
    input  logic                   wrreq,
    input  logic [7:0]             miso_reg,
    output logic [8*MAX_BYTES-1:0] rd_data,
    output logic                   rd_valid,
    output logic [2:0]             dbg_state
);

    localparam int DW = 8 * MAX_BYTES;
    localparam int CW = $clog2(MAX_BYTES + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INSTR   = 3'd1,
        S_DATA    = 3'd2,
        S_WAIT_CS = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_have_data;
    logic [7:0]      r_data_o;
    logic            r_frame_done;
    logic            r_rw;
    logic [CW-1:0]   r_cnt;
    logic [DW-1:0]   r_payload;
    logic [GW-1:0]   r_gap;

    logic [CW-1:0]   w_len_clamp;
    logic [DW-1:0]   w_payload_aligned;
    logic [DW-1:0]   w_payload_next;
    logic [7:0]      w_instr;

    // Clamp the requested length, left-align the payload so the next byte
    // to send always sits in the top 8 bits, and build the instruction byte.
    always_comb begin
        if (int'(cmd_len) > MAX_BYTES) begin
            w_len_clamp = CW'(MAX_BYTES);
        end else begin
            w_len_clamp = CW'(cmd_len);
        end
        w_payload_aligned = cmd_data << (8 * (MAX_BYTES - int'(w_len_clamp)));
        w_payload_next    = r_payload << 8;
        w_instr           = '0;
        w_instr[ADDR_W-1:0] = cmd_addr;
        w_instr[7]        = cmd_rw;
    end

    // Command FSM: latches the command, presents bytes to the master, then
    // waits for cs_n release and the guard gap before accepting again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_have_data  <= 1'b0;
            r_data_o     <= 8'h00;
            r_frame_done <= 1'b0;
            r_rw         <= 1'b0;
            r_cnt        <= '0;
            r_payload    <= '0;
            r_gap        <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_rw        <= cmd_rw;
                        r_cnt       <= w_len_clamp;
                        r_payload   <= w_payload_aligned;
                        r_data_o    <= w_instr;
                        r_have_data <= 1'b1;
                        r_state     <= S_INSTR;
                    end
                end
                S_INSTR: begin
                    if (rdreq) begin
                        if (r_cnt != '0) begin
                            r_data_o <= r_payload[DW-1 -: 8];
                            r_state  <= S_DATA;
                        end else begin
                            r_have_data <= 1'b0;
                            r_state     <= S_WAIT_CS;
                        end
                    end
                end
                S_DATA: begin
                    if (rdreq) begin
                        r_payload <= w_payload_next;
                        r_data_o  <= w_payload_next[DW-1 -: 8];
                        r_cnt     <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_have_data <= 1'b0;
                            r_state     <= S_WAIT_CS;
                        end
                    end
                end
                S_WAIT_CS: begin
                    if (cs_n) begin
                        r_gap   <= GW'(GAP_CYCLES - 1);
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == '0) begin
                        r_frame_done <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_gap <= r_gap - GW'(1);
                    end
                end
                default: begin
                    r_have_data <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign have_data  = r_have_data;
    assign data_o     = r_data_o;
    assign frame_done = r_frame_done;
    assign dbg_state  = r_state;

`ifdef SPI_SER_RD_CAPTURE_EN
    logic [DW-1:0] r_rd_data;
    logic          r_rd_valid;
    logic          r_skip_first;
    logic          w_capture_window;

    assign w_capture_window = (r_state == S_INSTR) || (r_state == S_DATA) ||
                              (r_state == S_WAIT_CS);

    // Read capture: clear on read acceptance, drop the instruction-slot byte,
    // shift later bytes in from the right, flag valid with frame_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_skip_first <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if ((r_state == S_IDLE) && cmd_valid && cmd_rw) begin
                r_rd_data    <= '0;
                r_skip_first <= 1'b1;
            end else if (r_rw && wrreq && w_capture_window) begin
                if (r_skip_first) begin
                    r_skip_first <= 1'b0;
                end else begin
                    r_rd_data <= (r_rd_data << 8) | DW'(miso_reg);
                end
            end
            if ((r_state == S_GAP) && (r_gap == '0) && r_rw) begin
                r_rd_valid <= 1'b1;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`else
    logic w_unused;
    assign w_unused = ^{wrreq, miso_reg, r_rw};
    assign rd_data  = '0;
    assign rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_serializer.sv
// Testbench for spi_cmd_serializer: directed scenarios followed by random
// commands, with an emulated SPI master popping bytes and a reference model
// that derives the expected byte stream straight from the command fields.
module tb_spi_cmd_serializer;

    localparam int MAX_BYTES  = 8;
    localparam int GAP_CYCLES = 4;
    localparam int ADDR_W     = 5;
    localparam int DW         = 8 * MAX_BYTES;

    // clock / reset block
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [3:0]        cmd_len;
    logic [DW-1:0]     cmd_data;
    logic              have_data;
    logic [7:0]        data_o;
    logic              rdreq;
    logic              cs_n;
    logic              busy;
    logic              frame_done;
    logic              wrreq;
    logic [7:0]        miso_reg;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic [2:0]        dbg_state;

    spi_cmd_serializer #(
        .MAX_BYTES (MAX_BYTES),
        .GAP_CYCLES(GAP_CYCLES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .have_data (have_data),
        .data_o    (data_o),
        .rdreq     (rdreq),
        .cs_n      (cs_n),
        .busy      (busy),
        .frame_done(frame_done),
        .wrreq     (wrreq),
        .miso_reg  (miso_reg),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .dbg_state (dbg_state)
    );

    // scoreboard state
    int            vectors     = 0;
    int            miscompares = 0;
    logic [7:0]    exp_q[$];
    logic [7:0]    rx_q[$];
    logic [7:0]    miso_src[$];
    logic [DW-1:0] exp_rd_data = '0;
    bit            cur_rw      = 1'b0;
    bit            pend_wr     = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; a byte popped on the previous edge
    // is answered with a wrreq strobe carrying a received byte.
    task automatic tick();
        @(negedge clk);
        wrreq = 1'b0;
        if (pend_wr) begin
            wrreq = 1'b1;
            if (miso_src.size() > 0) miso_reg = miso_src.pop_front();
            else miso_reg = 8'($urandom);
            rx_q.push_back(miso_reg);
            pend_wr = 1'b0;
        end
    endtask

    // Reference model: byte stream of one command from its fields.
    task automatic model_cmd(input logic rw, input logic [ADDR_W-1:0] addr,
                             input logic [3:0] len, input logic [DW-1:0] data);
        int n;
        logic [7:0] instr;
        instr = 8'(addr) + (rw ? 8'd128 : 8'd0);
        exp_q.push_back(instr);
        n = (int'(len) > MAX_BYTES) ? MAX_BYTES : int'(len);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(data[8*i +: 8]);
        cur_rw = rw;
        rx_q.delete();
        if (rw) exp_rd_data = '0;
    endtask

    task automatic accept_checks();
        chk("have_data_rise", 64'(have_data), 64'd1);
        chk("cmd_ready_drop", 64'(cmd_ready), 64'd0);
        chk("busy_rise", 64'(busy), 64'd1);
    endtask

    // driver: offer a command and wait (bounded) for it to be taken
    task automatic send_cmd(input logic rw, input logic [ADDR_W-1:0] addr,
                            input logic [3:0] len, input logic [DW-1:0] data);
        int n;
        cmd_rw = rw; cmd_addr = addr; cmd_len = len; cmd_data = data;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("accept_timeout", 64'(n >= 200), 64'd0);
        model_cmd(rw, addr, len, data);
        tick();
        cmd_valid = 1'b0;
        accept_checks();
    endtask

    // driver: master side of one frame, then cs_n release and gap timing
    task automatic master_frame(input int delay, input int cs_wait, input bit spurious);
        int k;
        logic [7:0] eb;
        logic [DW-1:0] acc;
        cs_n = 1'b0;
        while (exp_q.size() > 0) begin
            repeat (delay) tick();
            eb = exp_q.pop_front();
            chk("have_data", 64'(have_data), 64'd1);
            chk("busy", 64'(busy), 64'd1);
            chk("data_o", 64'(data_o), 64'(eb));
            rdreq = 1'b1;
            pend_wr = 1'b1;
            tick();
            rdreq = 1'b0;
        end
        chk("have_data_fall", 64'(have_data), 64'd0);
        for (int i = 0; i < cs_wait; i++) begin
            rdreq = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            chk("frame_done_early", 64'(frame_done), 64'd0);
            chk("have_data_wait", 64'(have_data), 64'd0);
        end
        cs_n = 1'b1;
        k = 0;
        do begin
            rdreq = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            k++;
        end while (frame_done !== 1'b1 && k < 40);
        rdreq = 1'b0;
        chk("frame_done_latency", 64'(k), 64'(GAP_CYCLES + 1));
        chk("cmd_ready_return", 64'(cmd_ready), 64'd1);
        chk("busy_clear", 64'(busy), 64'd0);
`ifdef SPI_SER_RD_CAPTURE_EN
        if (cur_rw) begin
            acc = '0;
            for (int i = 1; i < rx_q.size(); i++) acc = (acc << 8) | DW'(rx_q[i]);
            exp_rd_data = acc;
        end
        chk("rd_valid_pulse", 64'(rd_valid), 64'(cur_rw));
        chk("rd_data", rd_data, exp_rd_data);
`else
        acc = '0;
        chk("rd_valid_off", 64'(rd_valid), 64'd0);
        chk("rd_data_off", rd_data, acc);
`endif
        tick();
        chk("frame_done_one_cycle", 64'(frame_done), 64'd0);
        chk("rd_valid_one_cycle", 64'(rd_valid), 64'd0);
    endtask

    initial begin : main
        logic [DW-1:0] rdat;
        rst = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0;
        cmd_len = '0; cmd_data = '0; rdreq = 1'b0; cs_n = 1'b1;
        wrreq = 1'b0; miso_reg = '0;
        repeat (3) tick();

        // reset values
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_have_data", 64'(have_data), 64'd0);
        chk("rst_data_o", 64'(data_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        rst = 1'b1;
        tick();

        // write 0x0E, len 2, payload 0x1234, slow master
        send_cmd(1'b0, 5'h0E, 4'd2, 64'h1234);
        chk("model_first_bytes", 64'({exp_q[0], exp_q[1], exp_q[2]}), 64'h0E1234);
        master_frame(8, 2, 1'b0);

        // read 0x1F, instruction only
        send_cmd(1'b1, 5'h1F, 4'd0, 64'h0);
        master_frame(1, 0, 1'b0);

        // over-long length clamps to MAX_BYTES
        rdat = {$urandom, $urandom};
        send_cmd(1'b0, 5'h03, 4'd12, rdat);
        chk("clamp_stream_len", 64'(exp_q.size()), 64'(MAX_BYTES + 1));
        master_frame(0, 1, 1'b0);

        // command held valid during a frame, spurious rdreq while idle-ish
        send_cmd(1'b0, 5'h05, 4'd3, 64'hA1B2C3);
        cmd_rw = 1'b1; cmd_addr = 5'h0A; cmd_len = 4'd2; cmd_data = 64'h5566;
        cmd_valid = 1'b1;
        master_frame(2, 3, 1'b1);
        model_cmd(1'b1, 5'h0A, 4'd2, 64'h5566);
        cmd_valid = 1'b0;
        accept_checks();
        master_frame(1, 1, 1'b1);

        // reset in the middle of a 4-byte write
        send_cmd(1'b0, 5'h11, 4'd4, 64'hCAFEF00D);
        cs_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("pre_rst_data_o", 64'(data_o), 64'(exp_q.pop_front()));
            rdreq = 1'b1;
            pend_wr = 1'b1;
            tick();
            rdreq = 1'b0;
        end
        rst = 1'b0;
        tick();
        chk("midrst_have_data", 64'(have_data), 64'd0);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midrst_no_frame_done", 64'(frame_done), 64'd0);
        end
        exp_q.delete();
        exp_rd_data = '0;
        cs_n = 1'b1;
        rst = 1'b1;
        tick();
        send_cmd(1'b0, 5'h11, 4'd4, 64'hCAFEF00D);
        master_frame(0, 0, 1'b0);

        // read 0x01, len 4, returned bytes xx DE AD BE EF
        miso_src = '{8'h5A, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_cmd(1'b1, 5'h01, 4'd4, {$urandom, $urandom});
        master_frame(1, 1, 1'b0);
`ifdef SPI_SER_RD_CAPTURE_EN
        chk("rd_deadbeef", 64'(rd_data[31:0]), 64'hDEADBEEF);
`endif

        // random commands
        for (int t = 0; t < 14; t++) begin
            send_cmd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                     4'($urandom_range(0, 15)), {$urandom, $urandom});
            master_frame($urandom_range(0, 3), $urandom_range(0, 3),
                         1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_cmd_serializer.md
Name: spi_cmd_serializer

Overview:
- Upstream stage of spi_master_byte; replaces the raw byte FIFO on its have_data/data_i/rdreq interface.
- Accepts one register command (read/write, 5-bit address, up to 8 data bytes) per handshake and emits it as an ordered byte stream: instruction byte, then data bytes MSB first.
- Between commands, holds have_data low until the master has released cs_n, then waits a guard gap, so every command is a separate SPI frame with its own io_update.

Parameters:
- MAX_BYTES, 8, maximum data bytes per command; cmd_data width is 8*MAX_BYTES.
- GAP_CYCLES, 4, clk cycles have_data is held low after cs_n returns high before the next command is accepted; minimum 1.
- ADDR_W, 5, register address width; must be 7 or less.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  serializer can accept a command.
- cmd_rw  in  1  1 = read, 0 = write.
- cmd_addr  in  ADDR_W  register address.
- cmd_len  in  4  number of data bytes, 0..MAX_BYTES.
- cmd_data  in  8*MAX_BYTES  payload, right-aligned; the first byte sent is cmd_data[8*len-1 -: 8].
- have_data  out  1  to master: a byte is presented on data_o.
- data_o  out  8  show-ahead byte to master.
- rdreq  in  1  from master: pop the current byte.
- cs_n  in  1  from master: frame-active indicator.
- busy  out  1  a command is in progress (state not IDLE).
- frame_done  out  1  one-cycle pulse when the GAP state ends.
- wrreq  in  1  from master: received byte strobe (used only with the optional feature).
- miso_reg  in  8  from master: received byte (used only with the optional feature).
- rd_data  out  8*MAX_BYTES  captured read payload.
- rd_valid  out  1  one-cycle pulse, read payload valid.

Behaviour:
- Reset: state IDLE. cmd_ready=1, have_data=0, data_o=0, busy=0, frame_done=0, rd_data=0, rd_valid=0. Internal counters and latched command cleared.
- Reset mid-frame: everything is abandoned immediately. The master sees have_data drop; no frame_done and no rd_valid pulse are issued.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch rw, addr, len and data, then go to INSTR.
  - INSTR: have_data=1, data_o = {rw, zero-padding, addr}, i.e. bit7=rw and the address in the low bits. On rdreq, go to DATA if len>0, otherwise to WAIT_CS.
  - DATA: have_data=1, data_o = current byte. On rdreq, shift the payload left by 8 and decrement the remaining count. Popping the last byte goes to WAIT_CS.
  - WAIT_CS: have_data=0. When cs_n is sampled 1, load the gap counter and go to GAP.
  - GAP: have_data=0. The counter runs GAP_CYCLES cycles. On expiry, pulse frame_done and return to IDLE.
- Timing:
  - cmd_ready is combinational from state and drops the cycle after acceptance.
  - have_data rises the cycle after acceptance.
  - data_o advances on the clk edge where rdreq=1; the new byte is valid the next cycle.
  - have_data falls on the edge that pops the last byte.
- cmd_len > MAX_BYTES is clamped to MAX_BYTES. cmd_len = 0 gives an instruction-only frame.
- rdreq while have_data=0 is ignored: no pointer change, no error.
- cmd_valid outside IDLE is ignored; the command is not latched or queued.
- If cs_n is already 1 on entry to WAIT_CS, leave after one cycle.
- Minimum command-to-command period: 1 + (len+1 pops) + cs_n wait + 1 + GAP_CYCLES cycles.

Optional Feature:
- Macro: SPI_SER_RD_CAPTURE_EN.
- Defined:
  - For read commands, count wrreq strobes during INSTR, DATA and WAIT_CS.
  - Discard the first received byte (the instruction slot).
  - Shift each following miso_reg into rd_data from the right: rd_data <= {rd_data, miso_reg}, truncated to 8*MAX_BYTES.
  - rd_valid pulses together with frame_done; rd_data holds until the next read command is accepted, which clears it.
  - Write commands never pulse rd_valid.
- Undefined: wrreq and miso_reg are unused; rd_data=0 and rd_valid=0 constantly.

Test Plan:
- Write, addr 0x0E, len 2, data 0x...1234, master pops each byte 8 cycles after have_data -> data_o sequence 0x0E, 0x12, 0x34; have_data drops after the 3rd pop; frame_done pulses exactly GAP_CYCLES+1 cycles after cs_n rises; cmd_ready returns to 1.
- Read, addr 0x1F, len 0 -> single byte 0x9F; one frame_done pulse; with SPI_SER_RD_CAPTURE_EN, rd_valid pulses and rd_data=0.
- cmd_len=12 with MAX_BYTES=8 -> exactly 9 bytes emitted (instruction plus 8); the 8 data bytes are the top 8 bytes of cmd_data.
- Held cmd_valid during an active frame, plus rdreq pulses while have_data=0 -> second command accepted only after frame_done; spurious rdreq does not skip any byte.
- rst asserted low after the 2nd byte of a 4-byte write -> next cycle: have_data=0, cmd_ready=1, busy=0; no frame_done; a fresh command afterwards emits its full sequence from the instruction byte.
- SPI_SER_RD_CAPTURE_EN, read addr 0x01, len 4, model returns miso bytes 0xXX, 0xDE, 0xAD, 0xBE, 0xEF -> rd_data low 32 bits = 0xDEADBEEF; rd_valid is a one-cycle pulse coincident with frame_done.
